// File: rtl/embertrail_mem_pkg.sv
// Shared definitions for the Embertrail data-memory path: access direction,
// FSM state type, lane indices and packed-bus slice helpers.
package embertrail_mem_pkg;

  localparam int LANE_W = 16;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

  localparam int LANE1 = 0;
  localparam int LANE2 = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } mem_state_t;

  // Packed buses carry lane 1 in the low half and lane 2 in the high half.
  function automatic logic [LANE_W-1:0] lane1_of(input logic [2*LANE_W-1:0] bus);
    return bus[LANE_W-1:0];
  endfunction

  function automatic logic [LANE_W-1:0] lane2_of(input logic [2*LANE_W-1:0] bus);
    return bus[2*LANE_W-1:LANE_W];
  endfunction

endpackage

// File: rtl/embertrail_spram.sv
// Single-port synchronous RAM: one access per cycle, registered read data.
// Contents are never cleared; rdata holds until the next read.
module embertrail_spram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/embertrail_data_mem.sv
// Dual-lane data-memory responder: serialises two-lane requests onto one
// single-port RAM, lane 1 first, stalling the core for one cycle on a dual request.
//
//   state  | meaning
//   IDLE   | accepting requests from both lanes
//   SECOND | servicing the held lane 2 request; inputs ignored, oBusy high
module embertrail_data_mem
  import embertrail_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [31:0]       iDataAddrBus,
  input  logic [31:0]       iDataDataBus,
  input  logic              iData1BusEn,
  input  logic              iData2BusEn,
  input  logic              iDataMem1RW,
  input  logic              iDataMem2RW,
  output logic [31:0]       oDataDataBus,
  output logic [1:0]        oDataValid,
  output logic              oBusy
);

  mem_state_t state, state_nxt;

  logic [DEPTH_LOG2-1:0] hold_addr;
  logic [DATA_W-1:0]     hold_data;
  logic                  hold_rw;
  logic                  capture;

  logic                  ram_en;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  logic [1:0]            valid, valid_nxt;
  logic [DATA_W-1:0]     lane1_q, lane2_q;

  logic [15:0]           addr1, addr2;
  logic [DATA_W-1:0]     data1, data2;
  logic                  unused_addr_bits;

  assign addr1 = lane1_of(iDataAddrBus);
  assign addr2 = lane2_of(iDataAddrBus);
  assign data1 = lane1_of(iDataDataBus);
  assign data2 = lane2_of(iDataDataBus);

  // Upper address bits alias away by design.
  assign unused_addr_bits = ^iDataAddrBus;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = MEM_READ;
    ram_addr  = '0;
    ram_wdata = '0;
    valid_nxt = 2'b00;
    case (state)
      IDLE: begin
        if (iData1BusEn) begin
          ram_en           = 1'b1;
          ram_we           = iDataMem1RW;
          ram_addr         = addr1[DEPTH_LOG2-1:0];
          ram_wdata        = data1;
          valid_nxt[LANE1] = (iDataMem1RW == MEM_READ);
          if (iData2BusEn) begin
            capture   = 1'b1;
            state_nxt = SECOND;
          end
        end else if (iData2BusEn) begin
          ram_en           = 1'b1;
          ram_we           = iDataMem2RW;
          ram_addr         = addr2[DEPTH_LOG2-1:0];
          ram_wdata        = data2;
          valid_nxt[LANE2] = (iDataMem2RW == MEM_READ);
        end
      end
      SECOND: begin
        ram_en           = 1'b1;
        ram_we           = hold_rw;
        ram_addr         = hold_addr;
        ram_wdata        = hold_data;
        valid_nxt[LANE2] = (hold_rw == MEM_READ);
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset blocks the RAM port so it wins over any access at the same edge.
  embertrail_spram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_spram (
    .clk  (iClock),
    .en   (ram_en & ~iReset),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state     <= IDLE;
      hold_addr <= '0;
      hold_data <= '0;
      hold_rw   <= MEM_READ;
      valid     <= 2'b00;
      lane1_q   <= '0;
      lane2_q   <= '0;
    end else begin
      state <= state_nxt;
      valid <= valid_nxt;
      if (capture) begin
        hold_addr <= addr2[DEPTH_LOG2-1:0];
        hold_data <= data2;
        hold_rw   <= iDataMem2RW;
      end
      if (valid[LANE1]) lane1_q <= ram_rdata;
      if (valid[LANE2]) lane2_q <= ram_rdata;
    end
  end

  // Fresh RAM data is forwarded in its valid cycle, then parked per lane.
  assign oDataDataBus = {(valid[LANE2] ? ram_rdata : lane2_q),
                         (valid[LANE1] ? ram_rdata : lane1_q)};
  assign oDataValid   = valid;
  assign oBusy        = (state == SECOND);

endmodule

// File: doc/embertrail_data_mem.md
# embertrail_data_mem

Dual-lane data-memory responder for the Embertrail dual-issue core. It accepts the packed two-lane load/store requests that the control unit drives each cycle and services them against one single-port synchronous RAM. When both lanes request in the same cycle, lane 1 is serviced before lane 2 (program order), and the block stalls the core for one cycle. Registered read data comes back on the packed data bus with a per-lane valid strobe.

## Interface
- DEPTH_LOG2, default 10: RAM address width; depth is 2^DEPTH_LOG2 16-bit words.
- DATA_W, default 16: lane data width. Fixed at 16; the packed buses are 2*DATA_W wide.

Ports:
- iClock  in  1  sole clock; all state changes on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iDataAddrBus  in  32  {lane2 addr, lane1 addr}.
- iDataDataBus  in  32  write data, {lane2, lane1}.
- iData1BusEn  in  1  lane 1 request.
- iData2BusEn  in  1  lane 2 request.
- iDataMem1RW  in  1  lane 1 direction: 1 = write, 0 = read.
- iDataMem2RW  in  1  lane 2 direction: 1 = write, 0 = read.
- oDataDataBus  out  32  read data, {lane2, lane1}. Each half holds its value until that lane's next read completes.
- oDataValid  out  2  bit k-1 pulses for one cycle when lane k read data is updated.
- oBusy  out  1  registered stall. While high, the core holds its request and the block ignores new requests.

## Operation
- Address: only the low DEPTH_LOG2 bits of each 16-bit lane address are used. Upper bits are ignored, so addresses alias modulo the depth.
- FSM states:
  - IDLE: accepting requests.
  - SECOND: servicing the captured lane 2 request.
- Transitions from IDLE, at a rising edge:
  - No enable: stay in IDLE.
  - Exactly one enable: perform that lane's access; stay in IDLE.
  - Both enables: perform lane 1's access; latch lane 2's addr, data and RW into a holding register; go to SECOND.
- SECOND: perform the held lane 2 access at the next edge, then return to IDLE. All inputs are ignored in this state.
- Access semantics:
  - Write: the RAM word gets the lane data.
  - Read: the lane's output register gets the RAM word, and the lane's valid bit is set for the following cycle.
- Ordering: on a same-address dual request, lane 1 takes effect first.
  - Write/write: lane 2's value is stored.
  - Lane 1 write, lane 2 read: lane 2 returns the newly written value.
  - Lane 1 read, lane 2 write: lane 1 returns the old value.
- A lane 2-only request in IDLE takes one cycle and does not stall.

## Timing
- Reset values: state = IDLE, oBusy = 0, oDataValid = 2'b00, oDataDataBus = 0, holding register = 0. RAM contents are not cleared.
- Single-lane request sampled at edge N:
  - Write visible to a read sampled at edge N+1.
  - Read data and valid appear after edge N; valid is high during cycle N+1 only.
- Dual request sampled at edge N:
  - oBusy high during cycle N+1.
  - Lane 1 read valid during cycle N+1; lane 2 read valid during cycle N+2.
  - A new request is accepted at edge N+2 at the earliest.
- Back-to-back single-lane requests sustain one access per cycle with no bubbles.
- Reset asserted while in SECOND: the pending lane 2 access is discarded (no RAM write, no valid pulse), and the block is in IDLE with oBusy = 0 after that edge. Lane 1's access from the accepting edge has already been committed.
- Reset has priority over every access at the same edge.

## Structure
- Shared package embertrail_mem_pkg:
  - MEM_WRITE = 1, MEM_READ = 0.
  - FSM state type (IDLE, SECOND).
  - Lane index constants.
  - Packed-bus slice helpers (lane1 = [15:0], lane2 = [31:16]), also to be used by the control unit.
- Sub-module embertrail_spram: single-port RAM, one access per cycle, synchronous write, synchronous registered read, parameterised on DEPTH_LOG2 and DATA_W.
- Top level: FSM, holding register, RAM port mux, per-lane output registers.

## Test plan
- Lane 1 write 0xBEEF to addr 0x0005, then next cycle lane 1 read 0x0005 -> oDataDataBus[15:0] = 0xBEEF with oDataValid = 2'b01 for one cycle; oBusy stays 0.
- Dual write in one cycle, lane 1 0x1111 and lane 2 0x2222, both to addr 0x0010 -> oBusy = 1 for exactly one cycle; a subsequent lane 1 read of 0x0010 returns 0x2222.
- Dual request, lane 1 write 0xA5A5 to 0x0020 and lane 2 read 0x0020 -> lane 2 valid two cycles after the request with oDataDataBus[31:16] = 0xA5A5; lane 1 half unchanged.
- With DEPTH_LOG2 = 10: write 0x7777 to addr 0x0403, then read addr 0x0003 -> 0x7777 (aliasing).
- Dual write, lane 2 0x3333 to addr 0x0030, with iReset asserted during the SECOND cycle -> lane 2 write suppressed; no valid pulse; oBusy = 0; all outputs 0 after the reset edge; a later read of 0x0030 returns its prior contents.
- Lane 2-only read every cycle for 8 cycles at incrementing addresses -> one valid pulse per cycle on bit 1, correct data, oBusy never asserted.
